// File: rtl/jtopl_eg_pkg.sv
// rtl/jtopl_eg_pkg.sv - envelope generator shared types, step patterns and rate helper
package jtopl_eg_pkg;

    typedef enum logic [1:0] {
        EG_ATTACK  = 2'd0,
        EG_DECAY   = 2'd1,
        EG_SUSTAIN = 2'd2,
        EG_RELEASE = 2'd3
    } eg_state_t;

    localparam int NSLOTS_DEF = 18;

    // Index by rate fraction f, then by the 3-bit counter phase
    localparam logic [3:0][7:0] PAT = {8'b11111110, 8'b11101110, 8'b11101010, 8'b10101010};

    function automatic logic [5:0] eff_rate(input logic [3:0] base, input logic [3:0] ksr);
        logic [6:0] sum;
        sum = {1'b0, base, 2'b00} + {3'b000, ksr};
        if (base == 4'd0) return 6'd0;
        return (sum > 7'd63) ? 6'd63 : sum[5:0];
    endfunction

endpackage

// File: rtl/jtopl_eg_step.sv
// rtl/jtopl_eg_step.sv - effective rate plus envelope counter to step and sum_up strobes
module jtopl_eg_step
    import jtopl_eg_pkg::*;
#(
    parameter int CNTW = 15
) (
    input  logic [5:0]      r6,
    input  logic [CNTW-1:0] cnt,
    output logic            step,
    output logic            sum_up
);

    logic [3:0]      r;
    logic [1:0]      f;
    logic [3:0]      sh;
    logic [CNTW-1:0] mask;
    logic [CNTW-1:0] shifted;
    logic [2:0]      idx;

    always_comb begin
        r       = r6[5:2];
        f       = r6[1:0];
        // Shift only meaningful for r < 12; upper rates update every sample
        sh      = 4'd11 - r;
        mask    = (CNTW'(1) << sh) - CNTW'(1);
        shifted = cnt >> sh;
        idx     = cnt[2:0];
        step    = 1'b0;
        sum_up  = 1'b0;
        if (r6 == 6'd0) begin
            step   = 1'b0;
            sum_up = 1'b0;
        end else if (r < 4'd12) begin
            idx    = shifted[2:0];
            sum_up = ((cnt & mask) == '0);
            step   = PAT[f][idx];
        end else begin
            sum_up = 1'b1;
            step   = PAT[f][idx];
        end
    end

endmodule

// File: rtl/jtopl_eg_ctrl.sv
// rtl/jtopl_eg_ctrl.sv - per-slot ADSR phase tracking and rate/strobe timing for the OPL EG
module jtopl_eg_ctrl
    import jtopl_eg_pkg::*;
#(
    parameter int NSLOTS = NSLOTS_DEF,
    parameter int CNTW   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       zero,
    input  logic       keyon,
    input  logic       eg_type,
    input  logic [3:0] ar,
    input  logic [3:0] dr,
    input  logic [3:0] rr,
    input  logic [3:0] sl,
    input  logic [3:0] ksr_kc,
    input  logic [9:0] eg_cur,
    output logic       attack,
    output logic       step,
    output logic [4:0] rate,
    output logic       sum_up,
    output logic [1:0] eg_state
);

    localparam int SW = $clog2(NSLOTS);

    logic [SW-1:0]   slot_cnt;
    logic [CNTW-1:0] env_cnt;
    eg_state_t       st_mem  [NSLOTS];
    logic            kon_mem [NSLOTS];

    logic [SW-1:0] cur_slot;
    eg_state_t     cur_st;
    logic          cur_kon;
    eg_state_t     nxt_st;
    logic [4:0]    sl_eff;
    logic [3:0]    base;
    logic [5:0]    r6;
    logic          step_c;
    logic          sum_up_c;

    always_comb begin
        cur_slot = zero ? '0 : slot_cnt;
        cur_st   = st_mem[cur_slot];
        cur_kon  = kon_mem[cur_slot];
        sl_eff   = (sl == 4'd15) ? 5'd31 : {1'b0, sl};

        // Key-on edge wins over everything; key-off forces release from any live phase
        nxt_st = cur_st;
        if (keyon && !cur_kon)
            nxt_st = EG_ATTACK;
        else if (!keyon && cur_st != EG_RELEASE)
            nxt_st = EG_RELEASE;
        else if (cur_st == EG_ATTACK && eg_cur == 10'd0)
            nxt_st = EG_DECAY;
        else if (cur_st == EG_DECAY && eg_cur[9:5] >= sl_eff)
            nxt_st = EG_SUSTAIN;

        base = 4'd0;
        unique case (nxt_st)
            EG_ATTACK:  base = ar;
            EG_DECAY:   base = dr;
            EG_SUSTAIN: base = eg_type ? 4'd0 : rr;
            EG_RELEASE: base = rr;
        endcase
        r6 = eff_rate(base, ksr_kc);
    end

    jtopl_eg_step #(
        .CNTW(CNTW)
    ) u_step (
        .r6     (r6),
        .cnt    (env_cnt),
        .step   (step_c),
        .sum_up (sum_up_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOTS; i++) begin
                st_mem[i]  <= EG_RELEASE;
                kon_mem[i] <= 1'b0;
            end
            slot_cnt <= '0;
            env_cnt  <= '0;
            attack   <= 1'b0;
            step     <= 1'b0;
            rate     <= 5'd0;
            sum_up   <= 1'b0;
            eg_state <= 2'd3;
        end else if (cen) begin
            st_mem[cur_slot]  <= nxt_st;
            kon_mem[cur_slot] <= keyon;
            slot_cnt <= (cur_slot == SW'(NSLOTS - 1)) ? '0 : cur_slot + SW'(1);
            if (zero)
                env_cnt <= env_cnt + CNTW'(1);
            attack   <= (nxt_st == EG_ATTACK);
            step     <= step_c;
            rate     <= r6[5:1];
            sum_up   <= sum_up_c;
            eg_state <= nxt_st;
        end
    end

endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// tb/tb_jtopl_eg_ctrl.sv - scoreboard bench for jtopl_eg_ctrl with directed slot scenarios
module tb_jtopl_eg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       zero = 1'b0;
    logic       keyon = 1'b0;
    logic       eg_type = 1'b0;
    logic [3:0] ar = 4'd0, dr = 4'd0, rr = 4'd0, sl = 4'd0, ksr_kc = 4'd0;
    logic [9:0] eg_cur = 10'd0;
    logic       attack, step, sum_up;
    logic [4:0] rate;
    logic [1:0] eg_state;

    always #5 clk = ~clk;

    jtopl_eg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .keyon(keyon),
        .eg_type(eg_type), .ar(ar), .dr(dr), .rr(rr), .sl(sl), .ksr_kc(ksr_kc),
        .eg_cur(eg_cur), .attack(attack), .step(step), .rate(rate),
        .sum_up(sum_up), .eg_state(eg_state)
    );

    typedef struct packed {
        logic       attack;
        logic       step;
        logic [4:0] rate;
        logic       sum_up;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    exp_t obs[18];
    int vectors = 0;
    int miscompares = 0;

    int m_state[18];
    bit m_kon[18];
    int m_slot;
    int m_cnt;
    int pat_tab[4] = '{8'hAA, 8'hEA, 8'hEE, 8'hFE};

    bit k_a[18];
    bit t_a[18];
    int ar_a[18], dr_a[18], rr_a[18], sl_a[18], ks_a[18], cur_a[18];

    task automatic model_reset();
        for (int i = 0; i < 18; i++) begin
            m_state[i] = 3;
            m_kon[i] = 0;
        end
        m_slot = 0;
        m_cnt = 0;
        last_exp = '{attack: 1'b0, step: 1'b0, rate: 5'd0, sum_up: 1'b0, st: 2'd3};
    endtask

    task automatic model_visit(output exp_t e);
        int s, ns, base, r6, r, f, sh, idx, slv;
        s = zero ? 0 : m_slot;
        ns = m_state[s];
        slv = (sl == 4'd15) ? 31 : int'(sl);
        if (keyon && !m_kon[s]) ns = 0;
        else if (!keyon && ns != 3) ns = 3;
        else if (ns == 0 && eg_cur == 10'd0) ns = 1;
        else if (ns == 1 && int'(eg_cur) / 32 >= slv) ns = 2;
        case (ns)
            0: base = int'(ar);
            1: base = int'(dr);
            2: base = eg_type ? 0 : int'(rr);
            default: base = int'(rr);
        endcase
        r6 = (base == 0) ? 0 : base * 4 + int'(ksr_kc);
        if (r6 > 63) r6 = 63;
        e.attack = (ns == 0);
        e.rate = 5'(r6 / 2);
        e.st = 2'(ns);
        if (r6 == 0) begin
            e.sum_up = 1'b0;
            e.step = 1'b0;
        end else begin
            r = r6 / 4;
            f = r6 % 4;
            if (r < 12) begin
                sh = 11 - r;
                e.sum_up = ((m_cnt % (1 << sh)) == 0);
                idx = (m_cnt / (1 << sh)) % 8;
            end else begin
                e.sum_up = 1'b1;
                idx = m_cnt % 8;
            end
            e.step = 1'((pat_tab[f] >> idx) & 1);
        end
        m_state[s] = ns;
        m_kon[s] = keyon;
        m_slot = (s == 17) ? 0 : s + 1;
        if (zero) m_cnt = (m_cnt + 1) % 32768;
    endtask

    task automatic check_out(input string tag);
        exp_t want, got;
        want = sb.pop_front();
        got = {attack, step, rate, sum_up, eg_state};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic cyc(input bit c, input bit z);
        exp_t e;
        cen = c;
        zero = z;
        if (c) begin
            model_visit(e);
            last_exp = e;
        end
        sb.push_back(last_exp);
        @(posedge clk);
        #1;
        check_out("sb");
    endtask

    task automatic run_slots(input int n, input bit use_zero);
        for (int s = 0; s < n; s++) begin
            keyon = k_a[s]; eg_type = t_a[s];
            ar = 4'(ar_a[s]); dr = 4'(dr_a[s]); rr = 4'(rr_a[s]);
            sl = 4'(sl_a[s]); ksr_kc = 4'(ks_a[s]); eg_cur = 10'(cur_a[s]);
            cyc(1'b1, use_zero && s == 0);
            obs[s] = {attack, step, rate, sum_up, eg_state};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cen = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cen = 1'b0;
        model_reset();
    endtask

    initial begin
        int nsum, nstep;
        for (int i = 0; i < 18; i++) begin
            k_a[i] = 0; t_a[i] = 0; ar_a[i] = 0; dr_a[i] = 0; rr_a[i] = 0;
            sl_a[i] = 0; ks_a[i] = 0; cur_a[i] = 10'h3FF;
        end
        do_reset();
        chk("rst_state", int'(eg_state), 3);
        chk("rst_attack", int'(attack), 0);
        chk("rst_sum_up", int'(sum_up), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_rate", int'(rate), 0);

        run_slots(18, 1'b1);
        chk("idle_s0_state", int'(obs[0].st), 3);
        chk("idle_s17_state", int'(obs[17].st), 3);

        k_a[0] = 1; ar_a[0] = 15;
        k_a[3] = 1; ar_a[3] = 8;
        for (int fr = 0; fr < 3; fr++) begin
            run_slots(18, 1'b1);
            chk("s0_attack", int'(obs[0].attack), 1);
            chk("s0_rate", int'(obs[0].rate), 30);
            chk("s0_sum_up", int'(obs[0].sum_up), 1);
        end
        chk("s3_attack_state", int'(obs[3].st), 0);

        cur_a[3] = 0;
        run_slots(18, 1'b1);
        chk("s3_decay", int'(obs[3].st), 1);
        cur_a[3] = 10'h040; sl_a[3] = 2;
        run_slots(18, 1'b1);
        chk("s3_sustain", int'(obs[3].st), 2);
        run_slots(18, 1'b1);
        chk("s3_sus_rate", int'(obs[3].rate), 0);
        chk("s3_sus_sum_up", int'(obs[3].sum_up), 0);
        k_a[3] = 0;
        run_slots(18, 1'b1);
        chk("s3_release", int'(obs[3].st), 3);

        k_a[5] = 1; cur_a[5] = 0; sl_a[5] = 15; dr_a[5] = 4;
        run_slots(18, 1'b1);
        run_slots(18, 1'b1);
        chk("s5_decay", int'(obs[5].st), 1);
        chk("s5_rate", int'(obs[5].rate), 8);
        nsum = 0;
        nstep = 0;
        for (int fr = 0; fr < 1024; fr++) begin
            run_slots(18, 1'b1);
            nsum += int'(obs[5].sum_up);
            nstep += int'(obs[5].step);
        end
        chk("s5_sum_up_count", nsum, 8);
        chk("s5_step_count", nstep, 512);

        k_a[17] = 1; ar_a[17] = 15; ks_a[17] = 15;
        run_slots(18, 1'b1);
        chk("s17_clamp_rate", int'(obs[17].rate), 31);
        for (int i = 0; i < 5; i++) begin
            keyon = 1'($urandom_range(0, 1));
            ar = 4'($urandom_range(0, 15));
            eg_cur = 10'($urandom_range(0, 1023));
            cyc(1'b0, 1'b0);
            chk("frozen_rate", int'(rate), 31);
        end

        run_slots(1, 1'b0);
        chk("wrap_s0_attack", int'(obs[0].attack), 1);
        chk("wrap_s0_rate", int'(obs[0].rate), 30);
        run_slots(17, 1'b0);

        cur_a[0] = 0;
        run_slots(5, 1'b1);
        do_reset();
        run_slots(18, 1'b1);
        chk("postrst_s0_attack", int'(obs[0].st), 0);
        chk("postrst_s5_attack", int'(obs[5].st), 0);
        run_slots(18, 1'b1);
        chk("postrst_s0_decay", int'(obs[0].st), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
